// File: rtl/apb_acc_master.sv
// APB initiator: queues local read/write commands in a FIFO and issues them one at a time,
// returning one response per command. Optional access timeout under APB_MST_TIMEOUT_EN.
module apb_acc_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = APB_ADDR_WIDTH + 33;
  localparam logic [PtrW:0] PtrOne = 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e state_q, state_d;

  logic [EntryW-1:0] fifo_mem [FIFO_DEPTH];
  logic [EntryW-1:0] head;
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic              empty, full, push, pop;
  logic              timeout, complete;

  // Extra pointer bit distinguishes full from empty.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PtrW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
  end

`ifdef APB_MST_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == StSetup) begin
      to_cnt_q <= '0;
    end else if (state_q == StAccess && !PREADY) begin
      to_cnt_q <= to_cnt_q + CntW'(1);
    end
  end

  // Fires on the last permitted stalled ACCESS cycle so the transfer ends at that edge.
  assign timeout = (state_q == StAccess) && !PREADY &&
                   (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign complete = (state_q == StAccess) && (PREADY || timeout);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && (!rsp_valid || rsp_ready)) begin
          state_d = StSetup;
          pop     = 1'b1;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // The slot fills on this edge, so chaining needs the consumer ready now.
        if (complete) begin
          if (!empty && rsp_ready) begin
            state_d = StSetup;
            pop     = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else if (pop) begin
      PWRITE <= head[EntryW-1];
      PADDR  <= head[EntryW-2 -: APB_ADDR_WIDTH];
      PWDATA <= head[EntryW-1] ? head[31:0] : 32'h0;
    end else if (state_d == StIdle) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end
  end

  assign PSEL    = (state_q != StIdle);
  assign PENABLE = (state_q == StAccess);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (complete) begin
      rsp_valid <= 1'b1;
      rsp_write <= PWRITE;
      rsp_err   <= PREADY ? PSLVERR : 1'b1;
      rsp_rdata <= (!PWRITE && PREADY && !PSLVERR) ? PRDATA : 32'h0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = !empty || (state_q != StIdle) || rsp_valid;

endmodule

// File: tb/tb_apb_acc_master.sv
// Self-checking bench for apb_acc_master: a scoreboard queue holds the expected response of every
// accepted command and a monitor pops/compares each response handshake.
module tb_apb_acc_master;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  // Slave model: fixed read data, or an address-derived pattern to expose ordering.
  logic          use_fixed;
  logic [31:0]   fixed_val;
  assign PRDATA = use_fixed ? fixed_val : {8'hC3, 12'h000, PADDR};

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [33:0]   sb[$];
  logic [33:0]   exp_rsp;

  apb_acc_master #(
    .APB_ADDR_WIDTH(AW),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required run to complete");
    $fatal(1, "watchdog expired");
  end

  // Handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got write=%0b err=%0b rdata=%h, required no response",
                 rsp_write, rsp_err, rsp_rdata);
      end else begin
        exp_rsp = sb.pop_front();
        if ({rsp_write, rsp_err, rsp_rdata} !== exp_rsp) begin
          n_fail++;
          $display("FAIL rsp_data: got write=%0b err=%0b rdata=%h, required write=%0b err=%0b rdata=%h",
                   rsp_write, rsp_err, rsp_rdata, exp_rsp[33], exp_rsp[32], exp_rsp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic want_rsp, input logic [33:0] expv);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=0 after 50 cycles, required 1");
    end else if (want_rsp) begin
      sb.push_back(expv);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_write, rsp_err, busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/psel/pen/pwr/rv/rw/re/busy=%b, required 00000000",
               {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_write, rsp_err, busy});
    end
    n_checks++;
    if ({PADDR, PWDATA, rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h, required 0", PADDR, PWDATA,
               rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", cmd_ready);
    end
    tick();
  endtask

  task automatic test_write_latency();
    bit ok;
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    send_cmd(1'b1, 12'hFF0, 32'h1, 1'b1, {1'b1, 1'b0, 32'h0});
    // Cycle after the accept edge T: still idle, no bypass.
    n_checks++;
    if (PSEL !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_t0_psel: got %b, required 0", PSEL);
    end
    tick();
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 12'hFF0, 32'h1}) begin
      n_fail++;
      $display("FAIL wr_setup: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, required 1 0 1 ff0 1",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tick();
    n_checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      n_fail++;
      $display("FAIL wr_access: got psel/pen=%b, required 11", {PSEL, PENABLE});
    end
    tick();
    n_checks++;
    if ({rsp_valid, PSEL, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL wr_rsp_t3: got rv/psel/busy=%b, required 101", {rsp_valid, PSEL, busy});
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wr_drain: busy=1 after 200 cycles, required 0");
    end
  endtask

  task automatic test_read_wait();
    bit ok;
    int cnt = 0;
    int n = 0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    use_fixed = 1'b1;
    fixed_val = 32'h0001_2345;
    send_cmd(1'b0, 12'h004, 32'hFFFF_FFFF, 1'b1, {1'b0, 1'b0, 32'h0001_2345});
    while (n < 40 && !(cnt > 0 && !PENABLE)) begin
      if (PENABLE) begin
        cnt++;
        n_checks++;
        if ({PADDR, PWDATA, PWRITE} !== {12'h004, 32'h0, 1'b0}) begin
          n_fail++;
          $display("FAIL rd_stable: got paddr=%h pwdata=%h pwr=%b, required 004 0 0", PADDR,
                   PWDATA, PWRITE);
        end
        if (cnt == 4) PREADY = 1'b1;
      end
      tick();
      n++;
    end
    n_checks++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL rd_wait_len: got %0d PENABLE cycles, required 4", cnt);
    end
    wait_idle(ok);
    use_fixed = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rd_drain: busy=1 after 200 cycles, required 0");
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    int accepted = 0;
    PREADY = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 12'h100 + 12'(i * 4);
      cmd_wdata = '0;
      @(negedge clk);
      if (cmd_ready) begin
        accepted++;
        sb.push_back({1'b0, 1'b0, 8'hC3, 12'h000, cmd_addr});
      end
      tick();
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (accepted != 5) begin
      n_fail++;
      $display("FAIL full_accepted: got %0d, required 5", accepted);
    end
    n_checks++;
    if ({cmd_ready, PENABLE} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_ready: got rdy/pen=%b, required 01", {cmd_ready, PENABLE});
    end
    repeat (3) tick();
    PREADY = 1'b1;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL full_drain: busy=1 after 200 cycles, required 0");
    end
  endtask

  task automatic test_rsp_stall();
    bit ok;
    int n = 0;
    PREADY = 1'b1;
    rsp_ready = 1'b0;
    send_cmd(1'b1, 12'hFF4, 32'hAAAA_0001, 1'b1, {1'b1, 1'b0, 32'h0});
    send_cmd(1'b1, 12'hFF8, 32'h5555_0002, 1'b1, {1'b1, 1'b0, 32'h0});
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_first_rsp: got rsp_valid=%b, required 1", rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({PSEL, busy} !== 2'b01) begin
        n_fail++;
        $display("FAIL stall_hold: got psel/busy=%b, required 01", {PSEL, busy});
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if ({PSEL, PENABLE, PADDR, PWDATA} !== {2'b10, 12'hFF8, 32'h5555_0002}) begin
      n_fail++;
      $display("FAIL stall_release: got psel=%b pen=%b paddr=%h pwdata=%h, required 1 0 ff8 55550002",
               PSEL, PENABLE, PADDR, PWDATA);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_drain: busy=1 after 200 cycles, required 0");
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int run = 0;
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_cmd(1'b0, 12'h200 + 12'(i * 4), '0, 1'b1,
               {1'b0, 1'b0, 8'hC3, 12'h000, 12'h200 + 12'(i * 4)});
    end
    // First SETUP elapsed during the third push; ACCESS, then two more SETUP/ACCESS pairs remain.
    while (PSEL && run < 20) begin
      run++;
      tick();
    end
    n_checks++;
    if (run != 5) begin
      n_fail++;
      $display("FAIL b2b_psel_run: got %0d cycles, required 5", run);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_drain: busy=1 after 200 cycles, required 0");
    end
  endtask

  task automatic test_slverr_reset();
    bit ok;
    bit seen = 1'b0;
    int n = 0;
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    use_fixed = 1'b1;
    fixed_val = 32'hDEAD_BEEF;
    PSLVERR = 1'b1;
    send_cmd(1'b0, 12'h008, '0, 1'b1, {1'b0, 1'b1, 32'h0});
    wait_idle(ok);
    PSLVERR = 1'b0;
    use_fixed = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL err_drain: busy=1 after 200 cycles, required 0");
    end
    PREADY = 1'b0;
    send_cmd(1'b0, 12'h00C, '0, 1'b0, '0);
    while (!PENABLE && n < 10) begin
      tick();
      n++;
    end
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({PSEL, PENABLE, rsp_valid, busy, cmd_ready, PADDR} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got psel=%b pen=%b rv=%b busy=%b rdy=%b paddr=%h, required all 0",
               PSEL, PENABLE, rsp_valid, busy, cmd_ready, PADDR);
    end
    rst = 1'b0;
    PREADY = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || PSEL) seen = 1'b1;
    end
    tick();
    n_checks++;
    if (seen || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: got activity=%b rdy=%b, required activity=0 rdy=1", seen,
               cmd_ready);
    end
  endtask

`ifdef APB_MST_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int cnt = 0;
    int n = 0;
    PREADY = 1'b0;
    rsp_ready = 1'b0;
    PSLVERR = 1'b0;
    send_cmd(1'b0, 12'h010, '0, 1'b1, {1'b0, 1'b1, 32'h0});
    send_cmd(1'b1, 12'hFF0, 32'h1, 1'b1, {1'b1, 1'b0, 32'h0});
    while (n < 40 && !(cnt > 0 && !PENABLE)) begin
      if (PENABLE) cnt++;
      tick();
      n++;
    end
    n_checks++;
    if (cnt != 8) begin
      n_fail++;
      $display("FAIL to_len: got %0d ACCESS cycles, required 8", cnt);
    end
    n_checks++;
    if ({PSEL, rsp_valid, rsp_err, rsp_rdata} !== {3'b011, 32'h0}) begin
      n_fail++;
      $display("FAIL to_rsp: got psel=%b rv=%b err=%b rdata=%h, required 0 1 1 0", PSEL,
               rsp_valid, rsp_err, rsp_rdata);
    end
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL to_drain: busy=1 after 200 cycles, required 0");
    end
  endtask
`endif

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    use_fixed = 1'b0;
    fixed_val = '0;
    test_reset();
    test_write_latency();
    test_read_wait();
    test_fifo_full();
    test_rsp_stall();
    test_back_to_back();
    test_slverr_reset();
`ifdef APB_MST_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0d outstanding responses, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_acc_master.md
# apb_acc_master

APB initiator that issues single read/write transfers on behalf of a local command source, such as a test sequencer or a DMA-style loader. It drives the matrix accelerator's APB slave port: enable/disable writes at 0xFF0, A-stream writes at 0xFF4, X-stream writes at 0xFF8, and result reads from the RAM window. Commands are queued in a small FIFO and executed strictly in order. Each command produces exactly one response.

## Interface
Parameters:
- APB_ADDR_WIDTH, default 12: PADDR / cmd_addr width.
- FIFO_DEPTH, default 4: command FIFO entries; must be a power of two, at least 2.
- TIMEOUT_CYCLES, default 255: maximum ACCESS cycles with PREADY low. Used only when the timeout is compiled in.

Ports:
- clk  in  1: single clock, shared with the APB slave.
- rst  in  1: reset. Synchronous, active-high.
- cmd_valid  in  1: command offered.
- cmd_ready  out  1: FIFO can accept a command (FIFO not full).
- cmd_write  in  1: 1 = write, 0 = read.
- cmd_addr  in  APB_ADDR_WIDTH: target address.
- cmd_wdata  in  32: write data; ignored for reads.
- rsp_valid  out  1: response slot full.
- rsp_ready  in  1: response consumed.
- rsp_write  out  1: response belongs to a write.
- rsp_rdata  out  32: captured PRDATA; 0 for writes and for errors.
- rsp_err  out  1: PSLVERR at completion, or timeout.
- busy  out  1: FIFO non-empty, or transfer in progress, or rsp_valid.
- PADDR  out  APB_ADDR_WIDTH; PWDATA  out  32; PWRITE  out  1; PSEL  out  1; PENABLE  out  1
- PRDATA  in  32; PREADY  in  1; PSLVERR  in  1

## Operation
- The FIFO push condition is cmd_valid && cmd_ready. cmd_ready = !full; there is no bypass and no push when full, even if a pop happens in the same cycle.
- FSM states:
  - IDLE → SETUP when the FIFO is non-empty and the response slot is free (rsp_valid == 0, or rsp_ready == 1 in the same cycle).
  - On entering SETUP the head entry is popped into the transfer register.
  - SETUP → ACCESS unconditionally.
  - ACCESS → completion when PREADY == 1.
  - Completion → SETUP directly (no IDLE cycle) if the start condition still holds; otherwise → IDLE.
- APB outputs:
  - SETUP: PSEL = 1, PENABLE = 0.
  - ACCESS: PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE and PWDATA are registered and stable from SETUP through completion.
  - PWDATA = 0 for reads.
  - In IDLE all APB outputs are 0.
- At completion the response slot is loaded on the same edge:
  - rsp_write = PWRITE.
  - rsp_rdata = PRDATA for a read, 0 for a write.
  - rsp_err = PSLVERR.
  - rsp_valid is set.
  - For a read with PSLVERR = 1, rsp_rdata = 0.
- rsp_valid clears on rsp_valid && rsp_ready unless a new completion occurs in the same cycle. In that case the new response is loaded.
- Ordering: responses are returned in command order, and there is one transfer in flight at most.
- Reset:
  - All outputs go to 0 on the first clock edge with rst = 1. This includes cmd_ready = 0 during reset; cmd_ready = 1 on the first cycle after reset.
  - The FIFO is flushed, and any in-flight transfer and pending response are discarded with no response.
  - Reset during ACCESS drops PSEL/PENABLE at the next edge.

## Timing
- Command accepted at edge T, FIFO previously empty, response slot free:
  - SETUP during cycle T+1.
  - ACCESS during cycle T+2.
  - With PREADY = 1 at T+2, rsp_valid is high from cycle T+3.
- A wait of N cycles (PREADY low for N ACCESS cycles) adds N cycles.
- Back-to-back throughput: one transfer per 2 cycles when PREADY = 1 and rsp_ready is held at 1.
- A stalled response slot (rsp_ready = 0) blocks the next SETUP. It never stalls an ACCESS already in progress.

## Configuration
- APB_MST_TIMEOUT_EN defined:
  - A counter runs while in ACCESS with PREADY = 0.
  - When it reaches TIMEOUT_CYCLES, the transfer terminates at that edge: PSEL/PENABLE drop, the response is loaded with rsp_err = 1 and rsp_rdata = 0, and the FSM proceeds as for a normal completion.
  - The counter clears at each SETUP.
- APB_MST_TIMEOUT_EN undefined:
  - There is no counter, and ACCESS waits indefinitely for PREADY.
  - rsp_err reflects PSLVERR only.

## Test plan
- Write 0xFF0 ← 1 with PREADY tied 1, command accepted at T:
  - PSEL rises at T+1, PENABLE at T+2.
  - rsp_valid at T+3 with rsp_write = 1, rsp_err = 0, rsp_rdata = 0.
- Read 0x004, PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x0001_2345:
  - PENABLE is high for 4 cycles and PADDR is stable throughout.
  - rsp_rdata = 0x0001_2345.
- PREADY held 0, push 6 commands at FIFO_DEPTH = 4:
  - 5 are accepted (1 popped into SETUP, 4 queued), then cmd_ready = 0.
  - After PREADY is released, 5 responses arrive in push order.
- rsp_ready = 0 with 2 writes queued:
  - The first completes and the second SETUP is not issued.
  - Raising rsp_ready starts SETUP in that same cycle.
- Read with PSLVERR = 1 at completion → rsp_err = 1, rsp_rdata = 0. Then rst pulsed mid-ACCESS → all outputs 0 next cycle, no response produced, busy = 0.
- APB_MST_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, PREADY stuck 0:
  - After 8 ACCESS cycles PSEL drops, with rsp_err = 1 and rsp_rdata = 0.
  - The next queued command then proceeds normally.
